// File: rtl/axicb_slv_wr_arbiter_pkg.sv
// Shared definitions for the slave-side write arbiter: default geometry,
// index-width helper and the AW grant-lock state type.
package axicb_slv_wr_arbiter_pkg;

  localparam int MST_NB_DEF   = 4;
  localparam int AWCH_W_DEF   = 8;
  localparam int WCH_W_DEF    = 8;
  localparam int OSTD_NUM_DEF = 4;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // AW grant lock: HELD freezes the grant while a presented AW waits for ready.
  typedef enum logic [0:0] {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/axicb_slv_wr_arbiter_if.sv
// Bundle of the concatenated per-master AW/W channels and the shared
// slave-side write channels. The arbiter uses the slave view; whatever
// drives the masters and the downstream slave uses the master view.
interface axicb_slv_wr_arbiter_if
  import axicb_slv_wr_arbiter_pkg::*;
#(
  parameter int MST_NB = MST_NB_DEF,
  parameter int AWCH_W = AWCH_W_DEF,
  parameter int WCH_W  = WCH_W_DEF
);
  logic [MST_NB-1:0]        i_awvalid;
  logic [MST_NB-1:0]        i_awready;
  logic [MST_NB*AWCH_W-1:0] i_awch;
  logic [MST_NB-1:0]        i_wvalid;
  logic [MST_NB-1:0]        i_wready;
  logic [MST_NB-1:0]        i_wlast;
  logic [MST_NB*WCH_W-1:0]  i_wch;
  logic                     o_awvalid;
  logic                     o_awready;
  logic [AWCH_W-1:0]        o_awch;
  logic                     o_wvalid;
  logic                     o_wready;
  logic                     o_wlast;
  logic [WCH_W-1:0]         o_wch;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    output i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, o_awready, o_wready,
    input  i_awready, i_wready, o_awvalid, o_awch, o_wvalid, o_wlast, o_wch
  );
endinterface

// File: rtl/axicb_slv_wr_arbiter_rr_core.sv
// Mask-based round-robin arbiter with a grant lock. The pointer advances
// past the winner on ack; once a grant is presented without ack it is held
// until ack so the granted payload stays stable.
module axicb_slv_wr_arbiter_rr_core
  import axicb_slv_wr_arbiter_pkg::*;
#(
  parameter  int N = MST_NB_DEF,
  localparam int W = idx_w(N)
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         ack,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         locked
);

  logic [W-1:0] ptr_r;
  logic [W-1:0] hold_idx_r;
  lock_state_e  state_r;
  lock_state_e  state_s;
  logic [N-1:0] mask_s;
  logic [N-1:0] pick_s;
  logic [W-1:0] rr_idx_s;
  logic         any_s;

  // Round-robin pick: lowest request at/after the pointer, else lowest overall.
  always_comb begin
    mask_s   = '0;
    rr_idx_s = ptr_r;
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (i >= int'(ptr_r));
    end
    pick_s = (|(req & mask_s)) ? (req & mask_s) : req;
    for (int i = N - 1; i >= 0; i--) begin
      rr_idx_s = pick_s[i] ? W'(i) : rr_idx_s;
    end
  end

  // Grant selection (held index while locked) and lock next-state.
  always_comb begin
    any_s   = (|req) & en;
    gnt_idx = (state_r == LOCK_HELD) ? hold_idx_r : rr_idx_s;
    gnt     = '0;
    state_s = state_r;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any_s & (gnt_idx == W'(i));
    end
    case (state_r)
      LOCK_IDLE: state_s = (any_s & ~ack) ? LOCK_HELD : LOCK_IDLE;
      LOCK_HELD: state_s = ack ? LOCK_IDLE : LOCK_HELD;
      default:   state_s = LOCK_IDLE;
    endcase
  end

  assign locked = (state_r == LOCK_HELD);

  // Lock state, held index and round-robin pointer registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r    <= LOCK_IDLE;
      hold_idx_r <= '0;
      ptr_r      <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == LOCK_IDLE) begin
        hold_idx_r <= rr_idx_s;
      end
      if (ack) begin
        ptr_r <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
      end
    end
  end

endmodule

// File: rtl/axicb_slv_wr_arbiter.sv
// Shares one slave write path among several masters: round-robin AW
// arbitration, with granted indices queued in an order FIFO so W bursts
// are forwarded strictly in AW grant order.
module axicb_slv_wr_arbiter
  import axicb_slv_wr_arbiter_pkg::*;
#(
  parameter int MST_NB   = MST_NB_DEF,
  parameter int AWCH_W   = AWCH_W_DEF,
  parameter int WCH_W    = WCH_W_DEF,
  parameter int OSTD_NUM = OSTD_NUM_DEF
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axicb_slv_wr_arbiter_if.slave  bus,
  output logic                   o_wr_busy
);

  localparam int MST_W = idx_w(MST_NB);
  localparam int PTR_W = idx_w(OSTD_NUM);
  localparam int CNT_W = PTR_W + 1;

  logic [MST_W-1:0]  fifo_mem_r [OSTD_NUM];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic [MST_W-1:0]  head_s;
  logic [MST_NB-1:0] gnt_s;
  logic [MST_W-1:0]  gnt_idx_s;
  logic              lock_s;

  // Full is taken from the registered count, so a same-cycle pop never unblocks AW.
  assign fifo_full_s  = (cnt_r == CNT_W'(OSTD_NUM));
  assign fifo_empty_s = (cnt_r == CNT_W'(0));

  axicb_slv_wr_arbiter_rr_core #(.N(MST_NB)) u_rr_core (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (bus.i_awvalid),
    .en      (~fifo_full_s),
    .ack     (push_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .locked  (lock_s)
  );

  // Combinational AW path from the granted master to the slave.
  always_comb begin
    bus.o_awvalid = (|bus.i_awvalid) & ~fifo_full_s;
    bus.o_awch    = bus.i_awch[int'(gnt_idx_s) * AWCH_W +: AWCH_W];
    bus.i_awready = gnt_s & {MST_NB{bus.o_awready}};
    push_s        = bus.o_awvalid & bus.o_awready;
  end

  // W path follows the FIFO head; every other master is held off.
  always_comb begin
    head_s       = fifo_mem_r[rd_ptr_r];
    bus.o_wvalid = ~fifo_empty_s & bus.i_wvalid[head_s];
    bus.o_wlast  = bus.i_wlast[head_s];
    bus.o_wch    = bus.i_wch[int'(head_s) * WCH_W +: WCH_W];
    bus.i_wready = '0;
    for (int i = 0; i < MST_NB; i++) begin
      bus.i_wready[i] = ~fifo_empty_s & bus.o_wready & (head_s == MST_W'(i));
    end
    pop_s = bus.o_wvalid & bus.o_wready & bus.o_wlast;
  end

  assign o_wr_busy = ~fifo_empty_s | lock_s;

  // Order FIFO: granted index pushed on AW handshake, popped on last W beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      for (int i = 0; i < OSTD_NUM; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= gnt_idx_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule
